// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: control codes, FSM state and the
// NZCV flag bundle carried alongside every result.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b1010;
  localparam logic [3:0] OP_AND  = 4'b0110;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b1001;
  localparam logic [3:0] OP_NOR  = 4'b0101;
  localparam logic [3:0] OP_NAND = 4'b1100;
  localparam logic [3:0] OP_MOV  = 4'b1101;
  localparam logic [3:0] OP_CBZ  = 4'b0111;
  localparam logic [3:0] OP_LSL  = 4'b0011;
  localparam logic [3:0] OP_LSR  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1110;

  typedef enum logic [0:0] {
    StIdle,
    StMulRun
  } state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/seq_mul_unit.sv
// Iterative shift-and-add multiplier producing the low WIDTH bits of a*b.
// Ports:
//   clock, resetN  clock and asynchronous active-low reset
//   start          capture a/b and clear the accumulator
//   a, b           operands (sampled on start)
//   active         owner FSM is in its multiply state; iterate while high
//   out_free       result register can take the product this cycle
//   done           final iteration in progress; product is valid
//   product        accumulator plus the final partial product
module seq_mul_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             active,
  input  logic             out_free,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int unsigned NumIter = WIDTH / MUL_BITS;
  localparam int unsigned CntW    = (NumIter > 1) ? $clog2(NumIter) : 1;

  logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q;
  logic [CntW-1:0]  iter_q;
  logic [WIDTH-1:0] digit, partial, sum;
  logic             last, step;

  assign last    = (iter_q == CntW'(NumIter - 1));
  assign digit   = WIDTH'(b_sh_q[MUL_BITS-1:0]);
  assign partial = a_sh_q * digit;
  assign sum     = acc_q + partial;
  assign done    = active && last;
  assign product = sum;
  // The last iteration is held until the output register is free.
  assign step    = active && (!last || out_free);

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      acc_q  <= '0;
      iter_q <= '0;
    end else if (start) begin
      a_sh_q <= a;
      b_sh_q <= b;
      acc_q  <= '0;
      iter_q <= '0;
    end else if (step) begin
      acc_q  <= sum;
      a_sh_q <= a_sh_q << MUL_BITS;
      b_sh_q <= b_sh_q >> MUL_BITS;
      iter_q <= last ? '0 : iter_q + CntW'(1);
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes, NZCV flags, shifts and an
// iterative multiply.
// Ports:
//   clock, resetN            clock and asynchronous active-low reset
//   inValid/inReady          operand handshake (accept on inValid && inReady)
//   inOne, inTwo             operands A and B
//   aluControlCode           operation select
//   outValid/outReady        result handshake (consume on outValid && outReady)
//   result                   registered result
//   zero/neg/carry/overflowFlag  registered NZCV flags
//   busy                     multiply in progress
module seq_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned MUL_BITS = 1,
  parameter int unsigned SHAMT_W  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             resetN,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inOne,
  input  logic [WIDTH-1:0] inTwo,
  input  logic [3:0]       aluControlCode,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] result,
  output logic             zeroFlag,
  output logic             negFlag,
  output logic             carryFlag,
  output logic             overflowFlag,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  flags_t           flags_q;

  logic             out_free, accept, is_mul, mul_done;
  logic [WIDTH-1:0] mul_product;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH:0]     sum_full, diff_full, lsl_full, lsr_full;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  flags_t             alu_flags;

  assign out_free = !out_valid_q || outReady;
  assign inReady  = (state_q == StIdle) && out_free;
  assign accept   = inValid && inReady;
  assign is_mul   = (aluControlCode == OP_MUL);

  // Single-cycle datapath; carry bits fall out of one-bit-wider arithmetic.
  assign shamt     = inTwo[SHAMT_W-1:0];
  assign sum_full  = {1'b0, inOne} + {1'b0, inTwo};
  assign diff_full = {1'b0, inOne} + {1'b0, ~inTwo} + {{WIDTH{1'b0}}, 1'b1};
  assign lsl_full  = {1'b0, inOne} << shamt;
  assign lsr_full  = {inOne, 1'b0} >> shamt;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (aluControlCode)
      OP_ADD: begin
        alu_res = sum_full[WIDTH-1:0];
        alu_c   = sum_full[WIDTH];
        alu_v   = (inOne[WIDTH-1] == inTwo[WIDTH-1]) && (alu_res[WIDTH-1] != inOne[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff_full[WIDTH-1:0];
        alu_c   = diff_full[WIDTH];
        alu_v   = (inOne[WIDTH-1] != inTwo[WIDTH-1]) && (alu_res[WIDTH-1] != inOne[WIDTH-1]);
      end
      OP_AND:  alu_res = inOne & inTwo;
      OP_OR:   alu_res = inOne | inTwo;
      OP_XOR:  alu_res = inOne ^ inTwo;
      OP_NOR:  alu_res = ~(inOne | inTwo);
      OP_NAND: alu_res = ~(inOne & inTwo);
      OP_MOV:  alu_res = inOne;
      OP_CBZ:  alu_res = {{(WIDTH-1){1'b0}}, (inOne == '0)};
      OP_LSL: begin
        alu_res = lsl_full[WIDTH-1:0];
        alu_c   = lsl_full[WIDTH];
      end
      OP_LSR: begin
        alu_res = lsr_full[WIDTH:1];
        alu_c   = lsr_full[0];
      end
      default: alu_res = '0;
    endcase
  end

  assign alu_flags = '{n: alu_res[WIDTH-1], z: (alu_res == '0), c: alu_c, v: alu_v};

  seq_mul_unit #(
    .WIDTH    (WIDTH),
    .MUL_BITS (MUL_BITS)
  ) u_mul (
    .clock    (clock),
    .resetN   (resetN),
    .start    (accept && is_mul),
    .a        (inOne),
    .b        (inTwo),
    .active   (state_q == StMulRun),
    .out_free (out_free),
    .done     (mul_done),
    .product  (mul_product)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (accept && is_mul) state_d = StMulRun;
      StMulRun: if (mul_done && out_free) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else begin
      state_q <= state_d;
      if (accept && !is_mul) begin
        out_valid_q <= 1'b1;
        result_q    <= alu_res;
        flags_q     <= alu_flags;
      end else if (state_q == StMulRun && mul_done && out_free) begin
        out_valid_q <= 1'b1;
        result_q    <= mul_product;
        flags_q     <= '{n: mul_product[WIDTH-1], z: (mul_product == '0), c: 1'b0, v: 1'b0};
      end else if (out_valid_q && outReady) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign outValid     = out_valid_q;
  assign result       = result_q;
  assign negFlag      = flags_q.n;
  assign zeroFlag     = flags_q.z;
  assign carryFlag    = flags_q.c;
  assign overflowFlag = flags_q.v;
  assign busy         = (state_q == StMulRun);

endmodule

// File: tb/tb_seq_alu.sv
// Bench for seq_alu: a default instance plus a MUL_BITS=4 instance that only
// sees the multiply used for the latency comparison.
module tb_seq_alu;

  localparam logic [3:0] C_ADD = 4'b0010, C_SUB = 4'b1010, C_AND = 4'b0110, C_OR = 4'b0100;
  localparam logic [3:0] C_XOR = 4'b1001, C_NOR = 4'b0101, C_NAND = 4'b1100, C_MOV = 4'b1101;
  localparam logic [3:0] C_CBZ = 4'b0111, C_LSL = 4'b0011, C_LSR = 4'b1011, C_MUL = 4'b1110;

  typedef struct packed {
    logic [31:0] res;
    logic [3:0]  nzcv;
  } exp_t;

  typedef struct packed {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic [3:0]  nzcv;
  } vec_t;

  logic        clock = 1'b0;
  logic        resetN = 1'b0;
  logic        inValid = 1'b0;
  logic [31:0] inOne, inTwo;
  logic [3:0]  code;
  logic        outReady = 1'b0;
  logic        en4 = 1'b0;

  logic        in_ready, out_valid, busy, zf, nf, cf, vf;
  logic [31:0] result;
  logic        in_ready4, out_valid4, busy4, zf4, nf4, cf4, vf4;
  logic [31:0] result4;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  always #5 clock = ~clock;

  seq_alu dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(in_ready),
    .inOne(inOne), .inTwo(inTwo), .aluControlCode(code), .outValid(out_valid),
    .outReady(outReady), .result(result), .zeroFlag(zf), .negFlag(nf),
    .carryFlag(cf), .overflowFlag(vf), .busy(busy)
  );

  seq_alu #(.WIDTH(32), .MUL_BITS(4)) dut4 (
    .clock(clock), .resetN(resetN), .inValid(inValid && en4), .inReady(in_ready4),
    .inOne(inOne), .inTwo(inTwo), .aluControlCode(code), .outValid(out_valid4),
    .outReady(1'b1), .result(result4), .zeroFlag(zf4), .negFlag(nf4),
    .carryFlag(cf4), .overflowFlag(vf4), .busy(busy4)
  );

  function automatic logic [3:0] obs_flags();
    return {nf, zf, cf, vf};
  endfunction

  // Reference for ADD using 64-bit arithmetic.
  function automatic exp_t add_model(input logic [31:0] a, input logic [31:0] b);
    longint unsigned us;
    longint          ss;
    exp_t            e;
    us = {32'h0, a} + {32'h0, b};
    ss = longint'($signed(a)) + longint'($signed(b));
    e.res  = us[31:0];
    e.nzcv = {us[31], (us[31:0] == 32'h0), (us > 64'hFFFF_FFFF),
              (ss > 64'sd2147483647) || (ss < -64'sd2147483648)};
    return e;
  endfunction

  // Present an operation and return 1 time unit after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int guard;
    guard = 0;
    @(negedge clock);
    inValid = 1'b1; code = op; inOne = a; inTwo = b;
    #1;
    while (!in_ready && guard < 200) begin
      @(negedge clock); #1;
      guard++;
    end
    if (guard >= 200) begin
      checks++; errors++;
      $display("FAIL send_timeout: inReady stayed %b, required 1", in_ready);
    end
    @(posedge clock); #1;
    inValid = 1'b0; code = 'x; inOne = 'x; inTwo = 'x;
  endtask

  task automatic test_reset();
    resetN = 1'b0; inValid = 1'b0; code = 'x; inOne = 'x; inTwo = 'x; outReady = 1'b0;
    #12;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_outvalid: got %b required 0", out_valid); end
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h required 0", result); end
    checks++; if (obs_flags() !== 4'h0) begin errors++; $display("FAIL reset_flags: got %b required 0000", obs_flags()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
    @(negedge clock); resetN = 1'b1;
    @(posedge clock); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_inready: got %b required 1", in_ready); end
    checks++; if (result !== 32'h0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_x_inputs: result %h valid %b required 0 0", result, out_valid);
    end
  endtask

  task automatic test_single_cycle();
    vec_t v[$];
    exp_t e;
    v.push_back('{C_ADD, 32'd15, 32'd15, 32'd30, 4'b0000});
    v.push_back('{C_ADD, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 4'b1001});
    v.push_back('{C_SUB, 32'd10, 32'd15, 32'hFFFF_FFFB, 4'b1000});
    v.push_back('{C_SUB, 32'd15, 32'd15, 32'd0, 4'b0110});
    v.push_back('{C_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 4'b0011});
    v.push_back('{C_CBZ, 32'd0, 32'd0, 32'd1, 4'b0000});
    v.push_back('{C_CBZ, 32'd5, 32'd0, 32'd0, 4'b0100});
    v.push_back('{C_AND, 32'd5, 32'd10, 32'd0, 4'b0100});
    v.push_back('{C_OR, 32'd5, 32'd10, 32'd15, 4'b0000});
    v.push_back('{C_XOR, 32'd5, 32'd10, 32'd15, 4'b0000});
    v.push_back('{C_NOR, 32'd5, 32'd10, 32'hFFFF_FFF0, 4'b1000});
    v.push_back('{C_NAND, 32'd5, 32'd10, 32'hFFFF_FFFF, 4'b1000});
    v.push_back('{C_MOV, 32'h8000_0000, 32'd7, 32'h8000_0000, 4'b1000});
    v.push_back('{C_LSL, 32'h8000_0001, 32'd1, 32'd2, 4'b0010});
    v.push_back('{C_LSL, 32'hF000_0000, 32'd0, 32'hF000_0000, 4'b1000});
    v.push_back('{C_LSR, 32'd3, 32'd1, 32'd1, 4'b0010});
    v.push_back('{4'hF, 32'd5, 32'd10, 32'd0, 4'b0100});
    outReady = 1'b1;
    for (int i = 0; i < v.size(); i++) begin
      sb.push_back('{v[i].res, v[i].nzcv});
      send(v[i].op, v[i].a, v[i].b);
      e = sb.pop_front();
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL vec%0d_latency: outValid %b required 1", i, out_valid); end
      checks++; if (result !== e.res) begin errors++; $display("FAIL vec%0d_result: got %h required %h", i, result, e.res); end
      checks++; if (obs_flags() !== e.nzcv) begin errors++; $display("FAIL vec%0d_nzcv: got %b required %b", i, obs_flags(), e.nzcv); end
    end
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_outvalid: got %b required 0", out_valid); end
  endtask

  task automatic test_mul();
    exp_t        e;
    int          lat1, lat4, n_valid;
    bit          bad;
    logic [31:0] res1, res4;
    logic [3:0]  fl1;
    lat1 = 0; lat4 = 0; n_valid = 0; bad = 0; res1 = '0; res4 = '0; fl1 = '0;
    outReady = 1'b1;
    sb.push_back('{32'd7006652, 4'b0000});
    en4 = 1'b1;
    send(C_MUL, 32'd1234, 32'd5678);
    en4 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) begin @(posedge clock); #1; end
      if (out_valid) n_valid++;
      if (out_valid && lat1 == 0) begin lat1 = k; res1 = result; fl1 = obs_flags(); end
      if (out_valid4 && lat4 == 0) begin lat4 = k; res4 = result4; end
      if (lat1 == 0 && (!busy || in_ready)) bad = 1;
      if (k == 4) begin inValid = 1'b1; code = C_ADD; inOne = 32'd1; inTwo = 32'd1; end
      if (k == 5) begin inValid = 1'b0; code = 'x; inOne = 'x; inTwo = 'x; end
    end
    e = sb.pop_front();
    checks++; if (lat1 != 33) begin errors++; $display("FAIL mul_latency: got %0d required 33", lat1); end
    checks++; if (lat4 != 9) begin errors++; $display("FAIL mul4_latency: got %0d required 9", lat4); end
    checks++; if (res1 !== e.res) begin errors++; $display("FAIL mul_result: got %h required %h", res1, e.res); end
    checks++; if (fl1 !== e.nzcv) begin errors++; $display("FAIL mul_nzcv: got %b required %b", fl1, e.nzcv); end
    checks++; if (res4 !== e.res) begin errors++; $display("FAIL mul4_result: got %h required %h", res4, e.res); end
    checks++; if (bad) begin errors++; $display("FAIL mul_busy_inready: got busy0/ready1 during run, required busy1 ready0"); end
    checks++; if (n_valid != 1) begin errors++; $display("FAIL mul_extra_output: got %0d outputs required 1", n_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mul_busy_end: got %b required 0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] av[4] = '{32'd1, 32'd100, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    logic [31:0] bv[4] = '{32'd2, 32'd200, 32'd1, 32'h7FFF_FFFF};
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          sb.push_back(add_model(av[i], bv[i]));
          send(C_ADD, av[i], bv[i]);
        end
      end
      begin
        int          got;
        bit          held_v;
        logic [31:0] held;
        exp_t        e;
        got = 0; held_v = 0; held = '0;
        for (int c = 0; c < 40 && got < 4; c++) begin
          @(negedge clock);
          outReady = !(c >= 2 && c < 5);
          #1;
          if (out_valid && !outReady) begin
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_inready_full: got %b required 0", in_ready); end
            if (held_v) begin
              checks++; if (result !== held) begin errors++; $display("FAIL b2b_hold: got %h required %h", result, held); end
            end
            held = result; held_v = 1;
          end else begin
            held_v = 0;
          end
          if (out_valid && outReady) begin
            if (sb.size() == 0) begin
              checks++; errors++; $display("FAIL b2b_duplicate: got extra output %h required none", result);
            end else begin
              e = sb.pop_front();
              checks++; if (result !== e.res) begin errors++; $display("FAIL b2b_result%0d: got %h required %h", got, result, e.res); end
              checks++; if (obs_flags() !== e.nzcv) begin errors++; $display("FAIL b2b_nzcv%0d: got %b required %b", got, obs_flags(), e.nzcv); end
            end
            got++;
          end
        end
        checks++; if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d required 4", got); end
      end
    join
    outReady = 1'b1;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_leftover: got %0d required 0", sb.size()); end
  endtask

  task automatic test_reset_mid_mul();
    outReady = 1'b1;
    send(C_MUL, 32'd1234, 32'd5678);
    repeat (10) @(posedge clock);
    #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmm_busy_before: got %b required 1", busy); end
    resetN = 1'b0;
    #1;
    checks++; if (result !== 32'h0) begin errors++; $display("FAIL rmm_result: got %h required 0", result); end
    checks++; if (obs_flags() !== 4'h0) begin errors++; $display("FAIL rmm_flags: got %b required 0000", obs_flags()); end
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rmm_busy_valid: got %b%b required 00", busy, out_valid);
    end
    @(negedge clock); resetN = 1'b1;
    @(posedge clock); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rmm_inready: got %b required 1", in_ready); end
    sb.push_back('{32'd5, 4'b0000});
    send(C_ADD, 32'd2, 32'd3);
    begin
      exp_t e;
      e = sb.pop_front();
      checks++; if (out_valid !== 1'b1 || result !== e.res) begin
        errors++; $display("FAIL rmm_add: valid %b result %h required 1 %h", out_valid, result, e.res);
      end
    end
    @(posedge clock); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmm_no_late_mul: got %b required 0", out_valid); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_cycle();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
